// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared definitions for the RV32 decode path.
//   - opcode constants and the func3 encodings used by branch/load/store
//   - result_src / imm_src / alu_op encodings
//   - ctrl_t, the packed control bundle, its width, and a helper that
//     builds the all-zero bundle flagged as illegal
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BRCMP = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic [5:0] branch;   // {BGEU,BLTU,BGE,BLT,BNE,BEQ}
        logic [4:0] load;     // {LHU,LBU,LW,LH,LB}
        logic [2:0] store;    // {SW,SH,SB}
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Every control bit cleared, only the illegal flag raised.
    function automatic ctrl_t illegal_ctrl();
        ctrl_t c;
        c         = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// rv_ctrl_decode: combinational RV32 main decoder with illegal detection.
// Ports:
//   op    [6:0]  instruction opcode field (instr[6:0])
//   func3 [2:0]  instruction func3 field (instr[14:12])
//   ctrl         decoded control bundle; illegal encodings yield
//                all-zero controls with ctrl.illegal = 1
// SUPPORT_U = 0 treats LUI/AUIPC as illegal.
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_U = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] func3,
    output ctrl_t      ctrl
);

    ctrl_t ctrl_s;
    logic  bad_s;

    // Opcode/func3 decode; masks start at zero so nothing can carry over.
    always_comb begin
        ctrl_s = '0;
        bad_s  = 1'b0;
        case (op)
            OP_LOAD: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.result_src = RES_MEM;
                ctrl_s.imm_src    = IMM_I;
                ctrl_s.alu_op     = ALUOP_ADD;
                case (func3)
                    F3_LB:   ctrl_s.load = 5'b00001;
                    F3_LH:   ctrl_s.load = 5'b00010;
                    F3_LW:   ctrl_s.load = 5'b00100;
                    F3_LBU:  ctrl_s.load = 5'b01000;
                    F3_LHU:  ctrl_s.load = 5'b10000;
                    default: bad_s       = 1'b1;
                endcase
            end
            OP_STORE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.imm_src   = IMM_S;
                ctrl_s.alu_op    = ALUOP_ADD;
                case (func3)
                    F3_SB:   ctrl_s.store = 3'b001;
                    F3_SH:   ctrl_s.store = 3'b010;
                    F3_SW:   ctrl_s.store = 3'b100;
                    default: bad_s        = 1'b1;
                endcase
            end
            OP_OP: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            OP_IMM: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.imm_src   = IMM_I;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                ctrl_s.imm_src = IMM_B;
                ctrl_s.alu_op  = ALUOP_BRCMP;
                case (func3)
                    F3_BEQ:  ctrl_s.branch = 6'b000001;
                    F3_BNE:  ctrl_s.branch = 6'b000010;
                    F3_BLT:  ctrl_s.branch = 6'b000100;
                    F3_BGE:  ctrl_s.branch = 6'b001000;
                    F3_BLTU: ctrl_s.branch = 6'b010000;
                    F3_BGEU: ctrl_s.branch = 6'b100000;
                    default: bad_s         = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.jump       = 1'b1;
                ctrl_s.result_src = RES_PC4;
                ctrl_s.imm_src    = IMM_J;
            end
            OP_JALR: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.jump       = 1'b1;
                ctrl_s.jalr       = 1'b1;
                ctrl_s.result_src = RES_PC4;
                ctrl_s.imm_src    = IMM_I;
                if (func3 != 3'b000) begin
                    bad_s = 1'b1;
                end else begin
                    bad_s = 1'b0;
                end
            end
            OP_LUI: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.result_src = RES_IMM;
                ctrl_s.imm_src    = IMM_U;
                bad_s             = (SUPPORT_U == 0);
            end
            OP_AUIPC: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.imm_src   = IMM_U;
                ctrl_s.alu_op    = ALUOP_ADD;
                bad_s            = (SUPPORT_U == 0);
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Illegal encodings squash every control bit.
    always_comb begin
        if (bad_s) begin
            ctrl = illegal_ctrl();
        end else begin
            ctrl = ctrl_s;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked decode stage between fetch and execute.
// One output register backed by a single skid entry; in_ready is taken
// straight from the skid-full flop so out_ready never reaches it
// combinationally.
// Ports:
//   clk, rst (sync active-high), flush (drop held + incoming this cycle)
//   in_valid/in_ready/in_instr/in_pc        upstream handshake
//   out_valid/out_ready/out_instr/out_pc    downstream handshake
//   reg_write, mem_write, alu_src, jump, jalr, result_src, imm_src,
//   alu_op, branch, load, store, illegal     registered control bundle
//   ill_count  saturating count of illegal instructions handed downstream
module decode_stage
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SUPPORT_U = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             reg_write,
    output logic             mem_write,
    output logic             alu_src,
    output logic             jump,
    output logic             jalr,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [1:0]       alu_op,
    output logic [5:0]       branch,
    output logic [4:0]       load,
    output logic [2:0]       store,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        ctrl_t           ctrl;
    } entry_t;

    ctrl_t  dec_ctrl_s;
    entry_t in_entry_s;
    logic   in_acc_s;
    logic   out_hs_s;

    logic             out_valid_q, out_valid_d;
    entry_t           out_q, out_d;
    logic             skid_full_q, skid_full_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] ill_count_q, ill_count_d;

    rv_ctrl_decode #(
        .SUPPORT_U (SUPPORT_U)
    ) u_dec (
        .op    (in_instr[6:0]),
        .func3 (in_instr[14:12]),
        .ctrl  (dec_ctrl_s)
    );

    // Next-state for the output register, skid entry and counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        ill_count_d = ill_count_q;

        in_entry_s = '{instr: in_instr, pc: in_pc, ctrl: dec_ctrl_s};
        in_acc_s   = in_valid & ~skid_full_q;
        out_hs_s   = out_valid_q & out_ready;

        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            // in_ready is low here, so only the skid drain can happen.
            if (out_ready) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else begin
                out_d = out_q;
            end
        end else if (in_acc_s) begin
            if (!out_valid_q || out_ready) begin
                out_d       = in_entry_s;
                out_valid_d = 1'b1;
            end else begin
                skid_d      = in_entry_s;
                skid_full_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // A flushed cycle hands nothing downstream, so it never counts.
        if (!flush && out_hs_s && out_q.ctrl.illegal && (ill_count_q != {CNT_W{1'b1}})) begin
            ill_count_d = ill_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ill_count_d = ill_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            ill_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            ill_count_q <= ill_count_d;
        end
    end

    assign in_ready   = ~skid_full_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_q.instr;
    assign out_pc     = out_q.pc;
    assign reg_write  = out_q.ctrl.reg_write;
    assign mem_write  = out_q.ctrl.mem_write;
    assign alu_src    = out_q.ctrl.alu_src;
    assign jump       = out_q.ctrl.jump;
    assign jalr       = out_q.ctrl.jalr;
    assign result_src = out_q.ctrl.result_src;
    assign imm_src    = out_q.ctrl.imm_src;
    assign alu_op     = out_q.ctrl.alu_op;
    assign branch     = out_q.ctrl.branch;
    assign load       = out_q.ctrl.load;
    assign store      = out_q.ctrl.store;
    assign illegal    = out_q.ctrl.illegal;
    assign ill_count  = ill_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// Instance a: SUPPORT_U=1, CNT_W=16.  Instance b: SUPPORT_U=0, CNT_W=2
// (small counter so saturation is reachable).  Both share all inputs.
// Reference: a 2-deep in-order queue of accepted {instr,pc} plus a
// table-driven decode function and saturating illegal counters.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, reg_write_a, mem_write_a, alu_src_a, jump_a, jalr_a, illegal_a;
    logic [31:0] out_instr_a, out_pc_a;
    logic [1:0]  result_src_a, alu_op_a;
    logic [2:0]  imm_src_a, store_a;
    logic [5:0]  branch_a;
    logic [4:0]  load_a;
    logic [15:0] ill_count_a;

    logic        in_ready_b, out_valid_b, reg_write_b, mem_write_b, alu_src_b, jump_b, jalr_b, illegal_b;
    logic [31:0] out_instr_b, out_pc_b;
    logic [1:0]  result_src_b, alu_op_b;
    logic [2:0]  imm_src_b, store_b;
    logic [5:0]  branch_b;
    logic [4:0]  load_b;
    logic [1:0]  ill_count_b;

    logic [26:0] ctl_a, ctl_b;
    assign ctl_a = {reg_write_a, mem_write_a, alu_src_a, jump_a, jalr_a, result_src_a,
                    imm_src_a, alu_op_a, branch_a, load_a, store_a, illegal_a};
    assign ctl_b = {reg_write_b, mem_write_b, alu_src_b, jump_b, jalr_b, result_src_b,
                    imm_src_b, alu_op_b, branch_b, load_b, store_b, illegal_b};

    decode_stage #(.XLEN(32), .SUPPORT_U(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_instr(out_instr_a), .out_pc(out_pc_a), .reg_write(reg_write_a),
        .mem_write(mem_write_a), .alu_src(alu_src_a), .jump(jump_a), .jalr(jalr_a),
        .result_src(result_src_a), .imm_src(imm_src_a), .alu_op(alu_op_a),
        .branch(branch_a), .load(load_a), .store(store_a), .illegal(illegal_a),
        .ill_count(ill_count_a)
    );

    decode_stage #(.XLEN(32), .SUPPORT_U(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_instr(out_instr_b), .out_pc(out_pc_b), .reg_write(reg_write_b),
        .mem_write(mem_write_b), .alu_src(alu_src_b), .jump(jump_b), .jalr(jalr_b),
        .result_src(result_src_b), .imm_src(imm_src_b), .alu_op(alu_op_b),
        .branch(branch_b), .load(load_b), .store(store_b), .illegal(illegal_b),
        .ill_count(ill_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mq[$];     // {instr, pc} held in the stage, oldest first
    int          cnt_a = 0; // expected ill_count of instance a
    int          cnt_b = 0; // expected ill_count of instance b

    // Expected control bundle, packed in the same order as ctl_a/ctl_b.
    function automatic logic [26:0] exp_ctrl(input logic [31:0] instr, input bit su);
        int lpos[8] = '{0, 1, 2, -1, 3, 4, -1, -1};
        int spos[8] = '{0, 1, 2, -1, -1, -1, -1, -1};
        int bpos[8] = '{0, 1, -1, -1, 2, 3, 4, 5};
        logic [6:0] op = instr[6:0];
        int f3 = int'(instr[14:12]);
        logic rw = 1'b0, mw = 1'b0, as = 1'b0, j = 1'b0, jr = 1'b0;
        logic [1:0] rs = 2'd0, ao = 2'd0;
        logic [2:0] is = 3'd0, s = 3'd0;
        logic [5:0] b = 6'd0;
        logic [4:0] l = 5'd0;
        bit ill = 1'b0;
        case (op)
            7'h03: if (lpos[f3] < 0) ill = 1'b1;
                   else begin rw = 1'b1; as = 1'b1; rs = 2'd1; l = 5'd1 << lpos[f3]; end
            7'h23: if (spos[f3] < 0) ill = 1'b1;
                   else begin mw = 1'b1; as = 1'b1; is = 3'd1; s = 3'd1 << spos[f3]; end
            7'h33: begin rw = 1'b1; ao = 2'd2; end
            7'h13: begin rw = 1'b1; as = 1'b1; ao = 2'd2; end
            7'h63: if (bpos[f3] < 0) ill = 1'b1;
                   else begin is = 3'd2; ao = 2'd1; b = 6'd1 << bpos[f3]; end
            7'h6F: begin rw = 1'b1; j = 1'b1; rs = 2'd2; is = 3'd3; end
            7'h67: if (f3 != 0) ill = 1'b1;
                   else begin rw = 1'b1; as = 1'b1; j = 1'b1; jr = 1'b1; rs = 2'd2; end
            7'h37: if (!su) ill = 1'b1; else begin rw = 1'b1; rs = 2'd3; is = 3'd4; end
            7'h17: if (!su) ill = 1'b1; else begin rw = 1'b1; as = 1'b1; is = 3'd4; end
            default: ill = 1'b1;
        endcase
        if (ill) return 27'd1;
        return {rw, mw, as, j, jr, rs, is, ao, b, l, s, 1'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [31:0] r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    // Advance the reference model by one clock using the current inputs, then clock.
    task automatic step();
        bit acc;
        logic [63:0] head;
        if (rst) begin
            mq.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) begin
                head = mq.pop_front();
                if (exp_ctrl(head[63:32], 1'b1) == 27'd1 && cnt_a < 65535) cnt_a++;
                if (exp_ctrl(head[63:32], 1'b0) == 27'd1 && cnt_b < 3) cnt_b++;
            end
            if (acc) mq.push_back({in_instr, in_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic ordy);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = $urandom;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h0000707F, 1'b1);
        step(); step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid_a, out_valid_b);
        end
        n_checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b/%b expected 1", in_ready_a, in_ready_b);
        end
        n_checks++;
        if (ctl_a !== 27'd0 || ctl_b !== 27'd0) begin
            n_errors++; $display("FAIL reset_ctrl: got %h/%h expected 0", ctl_a, ctl_b);
        end
        n_checks++;
        if (out_instr_a !== 32'd0 || out_pc_a !== 32'd0 || ill_count_a !== 16'd0 || ill_count_b !== 2'd0) begin
            n_errors++; $display("FAIL reset_data: instr=%h pc=%h cnt=%0d/%0d expected all 0",
                                 out_instr_a, out_pc_a, ill_count_a, ill_count_b);
        end
    endtask

    task automatic test_beq();
        drive(1'b1, 32'h00A50463, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b1 || branch_a !== 6'b000001 || alu_op_a !== 2'b01 ||
            imm_src_a !== 3'b010 || illegal_a !== 1'b0) begin
            n_errors++; $display("FAIL beq: valid=%b branch=%b alu_op=%b imm=%b ill=%b expected 1 000001 01 010 0",
                                 out_valid_a, branch_a, alu_op_a, imm_src_a, illegal_a);
        end
        n_checks++;
        if (ctl_a !== exp_ctrl(32'h00A50463, 1'b1)) begin
            n_errors++; $display("FAIL beq_bundle: got %h expected %h", ctl_a, exp_ctrl(32'h00A50463, 1'b1));
        end
        step();
    endtask

    task automatic test_load_store();
        logic [2:0]  f3s[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = {12'h004, 5'd10, f3s[k], 5'd5, (k < 5) ? 7'h03 : 7'h23};
            drive(1'b1, w, 1'b1);
            step();
            n_checks++;
            if (k < 5) begin
                if (out_valid_a !== 1'b1 || load_a !== (5'd1 << k) || store_a !== 3'd0 || out_instr_a !== w) begin
                    n_errors++; $display("FAIL load_mask[%0d]: valid=%b load=%b store=%b expected 1 %b 000",
                                         k, out_valid_a, load_a, store_a, 5'd1 << k);
                end
            end else begin
                if (out_valid_a !== 1'b1 || store_a !== (3'd1 << (k - 5)) || load_a !== 5'd0 || out_instr_a !== w) begin
                    n_errors++; $display("FAIL store_mask[%0d]: valid=%b store=%b load=%b expected 1 %b 00000",
                                         k, out_valid_a, store_a, load_a, 3'd1 << (k - 5));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        logic [31:0] lw = 32'h00012083;
        logic [31:0] sw = 32'h00112223;
        drive(1'b1, lw, 1'b0);
        step();
        drive(1'b1, sw, 1'b0);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready_a !== 1'b0 || out_instr_a !== lw || load_a !== 5'b00100 || out_valid_a !== 1'b1) begin
            n_errors++; $display("FAIL stall_hold: in_ready=%b instr=%h load=%b expected 0 %h 00100",
                                 in_ready_a, out_instr_a, load_a, lw);
        end
        step();
        n_checks++;
        if (out_instr_a !== lw || ctl_a !== exp_ctrl(lw, 1'b1) || in_ready_a !== 1'b0) begin
            n_errors++; $display("FAIL stall_stable: instr=%h ctl=%h expected %h %h", out_instr_a, ctl_a, lw, exp_ctrl(lw, 1'b1));
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid_a !== 1'b1 || out_instr_a !== sw || store_a !== 3'b100 || in_ready_a !== 1'b1) begin
            n_errors++; $display("FAIL stall_drain_sw: valid=%b instr=%h store=%b in_ready=%b expected 1 %h 100 1",
                                 out_valid_a, out_instr_a, store_a, in_ready_a, sw);
        end
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_errors++; $display("FAIL stall_no_dup: out_valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ws[2] = '{32'h0000707F, 32'h00A52463};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, ws[k], 1'b1);
            step();
            n_checks++;
            if (out_valid_a !== 1'b1 || ctl_a !== 27'd1) begin
                n_errors++; $display("FAIL illegal[%0d]: valid=%b ctl=%h expected 1 0000001", k, out_valid_a, ctl_a);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (ill_count_a !== 16'd2 || ill_count_b !== 2'd2) begin
            n_errors++; $display("FAIL ill_count: got %0d/%0d expected 2/2", ill_count_a, ill_count_b);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0000707F, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (ill_count_b !== 2'd3 || ill_count_a !== 16'd6) begin
            n_errors++; $display("FAIL ill_saturate: got %0d/%0d expected 6/3", ill_count_a, ill_count_b);
        end
    endtask

    task automatic test_flush();
        int          cnt_before = cnt_a;
        logic [31:0] d = 32'h00500093;
        drive(1'b1, 32'h0000707F, 1'b0);
        step();
        drive(1'b1, 32'h00A50463, 1'b0);
        step();
        n_checks++;
        if (in_ready_a !== 1'b0) begin
            n_errors++; $display("FAIL flush_skid_full: in_ready=%b expected 0", in_ready_a);
        end
        flush = 1'b1;
        drive(1'b1, 32'h00112223, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || ill_count_a !== 16'(cnt_before)) begin
            n_errors++; $display("FAIL flush: valid=%b in_ready=%b cnt=%0d expected 0 1 %0d",
                                 out_valid_a, in_ready_a, ill_count_a, cnt_before);
        end
        drive(1'b1, d, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b1 || out_instr_a !== d) begin
            n_errors++; $display("FAIL flush_next: valid=%b instr=%h expected 1 %h", out_valid_a, out_instr_a, d);
        end
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_errors++; $display("FAIL flush_alone: out_valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_support_u();
        drive(1'b1, 32'h123452B7, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (reg_write_a !== 1'b1 || result_src_a !== 2'b11 || imm_src_a !== 3'b100 || illegal_a !== 1'b0) begin
            n_errors++; $display("FAIL lui_u1: rw=%b rs=%b imm=%b ill=%b expected 1 11 100 0",
                                 reg_write_a, result_src_a, imm_src_a, illegal_a);
        end
        n_checks++;
        if (illegal_b !== 1'b1 || ctl_b !== 27'd1) begin
            n_errors++; $display("FAIL lui_u0: ill=%b ctl=%h expected 1 0000001", illegal_b, ctl_b);
        end
        step();
    endtask

    task automatic test_random();
        logic [63:0] head;
        for (int c = 0; c < 800; c++) begin
            n_checks++;
            if (out_valid_a !== (mq.size() > 0) || out_valid_b !== (mq.size() > 0) ||
                in_ready_a !== (mq.size() < 2) || in_ready_b !== (mq.size() < 2)) begin
                n_errors++; $display("FAIL rand_hs cyc %0d: valid=%b/%b in_ready=%b/%b model depth %0d",
                                     c, out_valid_a, out_valid_b, in_ready_a, in_ready_b, mq.size());
            end
            if (mq.size() > 0) begin
                head = mq[0];
                n_checks++;
                if (out_instr_a !== head[63:32] || out_pc_a !== head[31:0] ||
                    ctl_a !== exp_ctrl(head[63:32], 1'b1) || ctl_b !== exp_ctrl(head[63:32], 1'b0)) begin
                    n_errors++; $display("FAIL rand_data cyc %0d: instr=%h pc=%h ctl=%h/%h expected %h %h %h/%h",
                                         c, out_instr_a, out_pc_a, ctl_a, ctl_b, head[63:32], head[31:0],
                                         exp_ctrl(head[63:32], 1'b1), exp_ctrl(head[63:32], 1'b0));
                end
            end
            n_checks++;
            if (ill_count_a !== 16'(cnt_a) || ill_count_b !== 2'(cnt_b)) begin
                n_errors++; $display("FAIL rand_count cyc %0d: got %0d/%0d expected %0d/%0d",
                                     c, ill_count_a, ill_count_b, cnt_a, cnt_b);
            end
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        test_reset();
        test_beq();
        test_load_store();
        test_stall();
        test_illegal();
        test_flush();
        test_support_u();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked successor to the combinational main decoder. It sits between fetch and execute and decodes op/func3 into the full control bundle, including one-hot branch/load/store masks. Decoded results are held in a 1-cycle pipeline register backed by a skid buffer. It adds JALR/LUI/AUIPC support, illegal-instruction detection with a counter, and a flush input.

Parameters:
XLEN, 32, width of the PC carried alongside the instruction.
SUPPORT_U, 1, when 1 LUI/AUIPC decode normally; when 0 they are flagged illegal.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all held and incoming instructions this cycle.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept; equals NOT skid_full.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction PC.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream accepts.
out_instr  out  32  registered instruction.
out_pc  out  XLEN  registered PC.
reg_write, mem_write, alu_src, jump, jalr  out  1 each  control bits.
result_src  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
branch  out  6  one-hot {BGEU,BLTU,BGE,BLT,BNE,BEQ}.
load  out  5  one-hot {LHU,LBU,LW,LH,LB}.
store  out  3  one-hot {SW,SH,SB}.
illegal  out  1  registered instruction is illegal.
ill_count  out  CNT_W  saturating count of illegal instructions handed downstream.

Behaviour:
- Reset (rst high at a clock edge) clears out_valid, skid_full, every control output, illegal and ill_count to 0. out_instr/out_pc are cleared to 0. in_ready reads 1 after reset.
- Decode is a pure function of op = instr[6:0] and func3 = instr[14:12]:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011 and JAL 1101111 decode exactly as in the existing decoder.
  - JALR 1100111: reg_write=1, alu_src=1, jump=1, jalr=1, result_src=10, imm_src=000.
  - LUI 0110111: reg_write=1, result_src=11, imm_src=100.
  - AUIPC 0010111: reg_write=1, alu_src=1, imm_src=100, alu_op=00.
- One-hot masks are fully assigned on every path; there are no latches and no sticky bits. At most one bit is set per mask.
- Illegal: unlisted opcode; BRANCH with func3 010/011; LOAD with func3 011/110/111; STORE with func3 ≥011; JALR with func3≠000; LUI/AUIPC when SUPPORT_U=0. An illegal instruction forces every control output to 0 and sets illegal=1. It still flows through with valid.
- Pipeline register: an input handshake (in_valid & in_ready) with the output register empty or draining (out_ready) loads the decoded bundle next cycle. Latency is exactly 1 cycle.
- Skid buffer: if the output register holds data, out_ready=0, and an input handshake occurs, the bundle goes to a single skid entry and skid_full=1, which drops in_ready. When out_ready rises, the skid entry moves to the output register. The same cycle may accept no new input; in_ready returns the cycle after.
- No combinational path from out_ready to in_ready.
- Output holds stable while out_valid=1 and out_ready=0.
- ill_count increments by 1 on each output handshake with illegal=1 and saturates at all-ones.
- flush has priority over the handshake. Next cycle: out_valid=0, skid_full=0, the input of the flush cycle is dropped, and ill_count is unchanged.
- Simultaneous rst and flush: reset wins.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - func3 constants for branch/load/store;
  - result_src and imm_src encodings;
  - the control-bundle struct/width constant.
- One sub-module, rv_ctrl_decode, is the combinational decoder including illegal detection, reused by this stage.
- decode_stage holds only the registers, skid buffer and counter.

Test Plan:
- After reset, drive instr 0x00A50463 (BEQ), in_valid=1, out_ready=1 -> next cycle out_valid=1, branch=000001, alu_op=01, imm_src=010, illegal=0.
- Back-to-back LB, LH, LW, LBU, LHU, SB, SH, SW with out_ready=1 -> masks strictly one-hot each cycle (load 00001…10000, store 001/010/100), with no bits carried over from the prior instruction.
- Stall: accept LW, hold out_ready=0, accept SW -> in_ready=0 on the following cycle and output holds the LW bundle. Raise out_ready -> LW then SW in order, no loss or duplication.
- Illegal word 0x0000707F, then BRANCH func3=010, accepted downstream -> illegal=1 and all control outputs 0 for each, ill_count=2. Force counter to all-ones -> it stays there.
- Stall with skid full, assert flush for one cycle -> next cycle out_valid=0, in_ready=1. The following instruction emerges alone one cycle after acceptance.
- SUPPORT_U=0 build, LUI 0x123452B7 -> illegal=1. SUPPORT_U=1 build -> reg_write=1, result_src=11, imm_src=100.
